// File: rtl/gpio_debounce.sv
// GPIO input conditioning: a 2-FF synchroniser and a per-bit stability filter clocked by a shared prescaled tick.
// Defining GPIO_DEBOUNCE_BYPASS_EN adds bypass_i, which passes the synchronised input straight to data_o for each selected bit.
module gpio_debounce #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = 1,
  parameter int STABLE_TICKS = 4
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] pin_i,
`ifdef GPIO_DEBOUNCE_BYPASS_EN
  input  logic [WIDTH-1:0] bypass_i,
`endif
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             tick_o
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] byp;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

`ifdef GPIO_DEBOUNCE_BYPASS_EN
  assign byp = bypass_i;
`else
  assign byp = '0;
`endif

  // The tick is registered so it reads 0 while reset is asserted, then is high for the cycle in which pre_q == PRESCALE-1.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    tick_d = (pre_d == PRE_LAST);
  end

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (byp[i]) begin
        data_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (sync2_q[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] >= CNT_LAST) begin
          data_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      data_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      data_q  <= data_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_o = data_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: stimulus pushes the expected strobe events, and per-instance monitors pop and compare them.
module tb_gpio_debounce;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  logic wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  logic       rst_a, rst_b, rst_c;
  logic [7:0] pin_a, pin_b, pin_c, bypass_c;
  logic [7:0] data_a, rise_a, fall_a;
  logic [7:0] data_b, rise_b, fall_b;
  logic [7:0] data_c, rise_c, fall_c;
  logic       tick_a, tick_b, tick_c;

  gpio_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_TICKS(4)) dut_a (
    .wb_clk(wb_clk), .wb_rst(rst_a), .pin_i(pin_a),
`ifdef GPIO_DEBOUNCE_BYPASS_EN
    .bypass_i(8'h00),
`endif
    .data_o(data_a), .rise_o(rise_a), .fall_o(fall_a), .tick_o(tick_a)
  );

  gpio_debounce #(.WIDTH(8), .PRESCALE(10), .STABLE_TICKS(4)) dut_b (
    .wb_clk(wb_clk), .wb_rst(rst_b), .pin_i(pin_b),
`ifdef GPIO_DEBOUNCE_BYPASS_EN
    .bypass_i(8'h00),
`endif
    .data_o(data_b), .rise_o(rise_b), .fall_o(fall_b), .tick_o(tick_b)
  );

`ifdef GPIO_DEBOUNCE_BYPASS_EN
  gpio_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_TICKS(4)) dut_c (
    .wb_clk(wb_clk), .wb_rst(rst_c), .pin_i(pin_c), .bypass_i(bypass_c),
    .data_o(data_c), .rise_o(rise_c), .fall_o(fall_c), .tick_o(tick_c)
  );
`else
  assign data_c = 8'h00;
  assign rise_c = 8'h00;
  assign fall_c = 8'h00;
  assign tick_c = 1'b0;
`endif

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int which, input int c, input logic [7:0] d,
                               input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.cyc = c; e.data = d; e.rise = r; e.fall = f;
    if (which == 0) qa.push_back(e);
    else if (which == 1) qb.push_back(e);
    else qc.push_back(e);
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // Strobe monitors: any nonzero rise/fall is one output event.
  always @(negedge wb_clk) begin
    if (!rst_a && ((rise_a | fall_a) != 8'h00)) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_strobe: got rise=%h fall=%h, required none (cycle %0d)", rise_a, fall_a, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_cycle", cyc, ea.cyc);
        chk("a_data", {24'h0, data_a}, {24'h0, ea.data});
        chk("a_rise", {24'h0, rise_a}, {24'h0, ea.rise});
        chk("a_fall", {24'h0, fall_a}, {24'h0, ea.fall});
      end
    end
  end

  always @(negedge wb_clk) begin
    if (!rst_b && ((rise_b | fall_b) != 8'h00)) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_strobe: got rise=%h fall=%h, required none (cycle %0d)", rise_b, fall_b, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_cycle", cyc, eb.cyc);
        chk("b_data", {24'h0, data_b}, {24'h0, eb.data});
        chk("b_rise", {24'h0, rise_b}, {24'h0, eb.rise});
        chk("b_fall", {24'h0, fall_b}, {24'h0, eb.fall});
      end
    end
  end

  always @(negedge wb_clk) begin
    if (!rst_c && ((rise_c | fall_c) != 8'h00)) begin
      if (qc.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL c_unexpected_strobe: got rise=%h fall=%h, required none (cycle %0d)", rise_c, fall_c, cyc);
      end else begin
        ec = qc.pop_front();
        chk("c_cycle", cyc, ec.cyc);
        chk("c_data", {24'h0, data_c}, {24'h0, ec.data});
        chk("c_rise", {24'h0, rise_c}, {24'h0, ec.rise});
        chk("c_fall", {24'h0, fall_c}, {24'h0, ec.fall});
      end
    end
  end

  // Prescaler monitor for the PRESCALE=10 instance.
  int kb = 0;
  int last_tb = -1;
  int n_tb = 0;
  always @(negedge wb_clk) begin
    if (!rst_b && tick_b) begin
      if (last_tb < 0) chk("b_tick_first", cyc, kb + 9);
      else if (n_tb < 6) chk("b_tick_period", cyc - last_tb, 10);
      last_tb = cyc;
      n_tb++;
    end
  end

  int k;
  int budget;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    pin_a = 8'hFF; pin_b = 8'h08; pin_c = 8'h00; bypass_c = 8'h01;
    @(posedge wb_clk); #1;
    wait_cyc(3);
    chk("rst_data_a", {24'h0, data_a}, 32'h0);
    chk("rst_rise_a", {24'h0, rise_a}, 32'h0);
    chk("rst_tick_a", {31'h0, tick_a}, 32'h0);
    chk("rst_data_b", {24'h0, data_b}, 32'h0);
    chk("rst_tick_b", {31'h0, tick_b}, 32'h0);

    // Release with all pins high: data_o follows 5 edges after the first post-reset edge.
    k = cyc; rst_a = 1'b0;
    push(0, k + 6, 8'hFF, 8'hFF, 8'h00);
    wait_cyc(k + 2);
    chk("a_tick_const", {31'h0, tick_a}, 32'h1);
    wait_cyc(k + 5);
    chk("a_data_before_commit", {24'h0, data_a}, 32'h0);
    wait_cyc(k + 10);

    k = cyc; pin_a = 8'h00;
    push(0, k + 6, 8'h00, 8'h00, 8'hFF);
    wait_cyc(k + 10);

    // Three-cycle glitch on bit 0: one tick short of committing.
    k = cyc; pin_a = 8'h01;
    wait_cyc(k + 3); pin_a = 8'h00;
    wait_cyc(k + 12);
    chk("a_glitch_data", {24'h0, data_a}, 32'h0);

    // Held high afterwards: full latency again, showing the count restarted.
    k = cyc; pin_a = 8'h01;
    push(0, k + 6, 8'h01, 8'h01, 8'h00);
    wait_cyc(k + 10);

    k = cyc; pin_a = 8'h41;
    push(0, k + 6, 8'h41, 8'h40, 8'h00);
    wait_cyc(k + 10);

    // Bits 1 and 6 toggle together in opposite directions.
    k = cyc; pin_a = 8'h03;
    push(0, k + 6, 8'h03, 8'h02, 8'h40);
    wait_cyc(k + 10);

    // Reset two counts into a change on bit 2.
    k = cyc; pin_a = 8'h07;
    wait_cyc(k + 4); rst_a = 1'b1;
    wait_cyc(k + 6);
    chk("a_midrst_data", {24'h0, data_a}, 32'h0);
    chk("a_midrst_rise", {24'h0, rise_a}, 32'h0);
    k = cyc; rst_a = 1'b0;
    push(0, k + 6, 8'h07, 8'h07, 8'h00);
    wait_cyc(k + 10);

    kb = cyc; rst_b = 1'b0;
    push(1, kb + 40, 8'h08, 8'h08, 8'h00);
    wait_cyc(kb + 45);
    pin_b = 8'h00;
    push(1, kb + 80, 8'h00, 8'h00, 8'h08);
    wait_cyc(kb + 90);

`ifdef GPIO_DEBOUNCE_BYPASS_EN
    k = cyc; rst_c = 1'b0;
    wait_cyc(k + 4);
    k = cyc; pin_c = 8'h03;
    push(2, k + 3, 8'h01, 8'h01, 8'h00);
    push(2, k + 5, 8'h00, 8'h00, 8'h01);
    push(2, k + 6, 8'h02, 8'h02, 8'h00);
    push(2, k + 7, 8'h03, 8'h01, 8'h00);
    push(2, k + 9, 8'h02, 8'h00, 8'h01);
    wait_cyc(k + 2); pin_c = 8'h02;
    wait_cyc(k + 4); pin_c = 8'h03;
    wait_cyc(k + 6); pin_c = 8'h02;
    wait_cyc(k + 12);
    k = cyc; bypass_c = 8'h00; pin_c = 8'h03;
    push(2, k + 6, 8'h03, 8'h01, 8'h00);
    wait_cyc(k + 10);
`endif

    budget = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && budget < 50) begin
      @(posedge wb_clk); #1;
      budget++;
    end
    while (qa.size() != 0) begin
      ea = qa.pop_front(); n_cmp++; n_err++;
      $display("FAIL a_missing_strobe: got none, required data=%h at cycle %0d", ea.data, ea.cyc);
    end
    while (qb.size() != 0) begin
      eb = qb.pop_front(); n_cmp++; n_err++;
      $display("FAIL b_missing_strobe: got none, required data=%h at cycle %0d", eb.data, eb.cyc);
    end
    while (qc.size() != 0) begin
      ec = qc.pop_front(); n_cmp++; n_err++;
      $display("FAIL c_missing_strobe: got none, required data=%h at cycle %0d", ec.data, ec.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
